// File: rtl/sd_chan_arb.sv
// sd_chan_arb: round-robin arbiter that shares one hps_io SD block-device
// port between up to four requesters. A granted channel keeps the port
// through one REQ/XFER/DONE handshake and is then rearbitrated.
// Optional build macro SD_ARB_TIMEOUT_EN: abandon a request that is never
// acknowledged within TIMEOUT cycles and flag it on ch_err.
module sd_chan_arb #(
    parameter int          CHANNELS = 2,
    parameter int          BUF_AW   = 8,
    parameter logic [23:0] TIMEOUT  = 24'd10_000_000
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [32*CHANNELS-1:0] ch_lba,
    input  logic [CHANNELS-1:0]    ch_rd,
    input  logic [CHANNELS-1:0]    ch_wr,
    output logic [CHANNELS-1:0]    ch_ack,
    output logic [CHANNELS-1:0]    ch_buff_wr,
    input  logic [16*CHANNELS-1:0] ch_buff_din,
    output logic [CHANNELS-1:0]    ch_err,
    output logic [31:0]            sd_lba,
    output logic                   sd_rd,
    output logic                   sd_wr,
    input  logic                   sd_ack,
    input  logic [BUF_AW-1:0]      sd_buff_addr,
    input  logic [15:0]            sd_buff_dout,
    output logic [15:0]            sd_buff_din,
    input  logic                   sd_buff_wr,
    output logic [1:0]             grant
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  grant_reg, grant_next;
    logic [31:0] lba_reg, lba_next;
    logic        wr_dir_reg, wr_dir_next;
    logic        sd_rd_reg, sd_rd_next;
    logic        sd_wr_reg, sd_wr_next;

    // Per-channel views padded to four entries so a 2-bit index is always legal.
    logic [31:0] lba_arr [4];
    logic [15:0] din_arr [4];
    logic [3:0]  req_vec;
    logic [3:0]  rd_vec;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pad
            if (gi < CHANNELS) begin : g_ch
                assign lba_arr[gi] = ch_lba[32*gi +: 32];
                assign din_arr[gi] = ch_buff_din[16*gi +: 16];
                assign req_vec[gi] = ch_rd[gi] | ch_wr[gi];
                assign rd_vec[gi]  = ch_rd[gi];
            end else begin : g_none
                assign lba_arr[gi] = 32'd0;
                assign din_arr[gi] = 16'd0;
                assign req_vec[gi] = 1'b0;
                assign rd_vec[gi]  = 1'b0;
            end
        end
    endgenerate

    // Buffer address/data from HPS go straight to the requesters outside this block.
    logic unused_ok;
    assign unused_ok = ^{sd_buff_addr, sd_buff_dout, TIMEOUT};

    // Round-robin pick: first requesting channel at grant+1, grant+2, ... (mod CHANNELS).
    logic       pick_valid;
    logic [1:0] pick_idx;
    logic [1:0] cand;
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        cand       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            if (k <= CHANNELS) begin
                cand = 2'((int'(grant_reg) + k) % CHANNELS);
                if (!pick_valid && req_vec[cand]) begin
                    pick_valid = 1'b1;
                    pick_idx   = cand;
                end
            end
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0]         cnt_reg, cnt_next;
    logic [CHANNELS-1:0] err_reg, err_next;
    assign ch_err = err_reg;
`else
    assign ch_err = '0;
`endif

    // Next-state logic; sd_rd/sd_wr are recomputed every cycle and registered.
    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        lba_next    = lba_reg;
        wr_dir_next = wr_dir_reg;
        sd_rd_next  = 1'b0;
        sd_wr_next  = 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
        cnt_next    = '0;
        err_next    = '0;
`endif
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next  = REQ;
                    grant_next  = pick_idx;
                    lba_next    = lba_arr[pick_idx];
                    wr_dir_next = !rd_vec[pick_idx];   // rd wins when both are set
                end
            end
            REQ: begin
                if (sd_ack) begin
                    state_next = XFER;
                end
`ifdef SD_ARB_TIMEOUT_EN
                else if (cnt_reg == TIMEOUT - 24'd1) begin
                    state_next = DONE;
                    err_next   = CHANNELS'(1) << grant_reg;
                end
`endif
                else begin
                    sd_rd_next = !wr_dir_reg;
                    sd_wr_next = wr_dir_reg;
`ifdef SD_ARB_TIMEOUT_EN
                    cnt_next   = cnt_reg + 24'd1;
`endif
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and handshake registers; reset clears them immediately.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            grant_reg  <= 2'(CHANNELS - 1);
            lba_reg    <= 32'd0;
            wr_dir_reg <= 1'b0;
            sd_rd_reg  <= 1'b0;
            sd_wr_reg  <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
            cnt_reg    <= '0;
            err_reg    <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            lba_reg    <= lba_next;
            wr_dir_reg <= wr_dir_next;
            sd_rd_reg  <= sd_rd_next;
            sd_wr_reg  <= sd_wr_next;
`ifdef SD_ARB_TIMEOUT_EN
            cnt_reg    <= cnt_next;
            err_reg    <= err_next;
`endif
        end
    end

    logic active;
    assign active = (state_reg == REQ) || (state_reg == XFER);

    // Route acknowledge and buffer strobes to the granted channel only.
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_route
            assign ch_ack[gi]     = active && (grant_reg == 2'(gi)) && sd_ack;
            assign ch_buff_wr[gi] = (state_reg == XFER) && (grant_reg == 2'(gi)) && sd_buff_wr;
        end
    endgenerate

    assign sd_buff_din = active ? din_arr[grant_reg] : 16'd0;
    assign sd_lba      = lba_reg;
    assign sd_rd       = sd_rd_reg;
    assign sd_wr       = sd_wr_reg;
    assign grant       = grant_reg;

endmodule

// File: tb/tb_sd_chan_arb.sv
// Testbench for sd_chan_arb (CHANNELS=2): table of single transfers plus
// hand-written sequences for long acks, fairness, reset and timeout.
module tb_sd_chan_arb;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [63:0] ch_lba;
    logic [1:0]  ch_rd, ch_wr;
    logic [1:0]  ch_ack, ch_buff_wr, ch_err;
    logic [31:0] ch_buff_din;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout, sd_buff_din;
    logic [1:0]  grant;

    int checks = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    sd_chan_arb #(.CHANNELS(2), .BUF_AW(8), .TIMEOUT(24'd16)) dut (
        .clk_sys(clk_sys), .reset(reset), .ch_lba(ch_lba), .ch_rd(ch_rd), .ch_wr(ch_wr),
        .ch_ack(ch_ack), .ch_buff_wr(ch_buff_wr), .ch_buff_din(ch_buff_din), .ch_err(ch_err),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din),
        .sd_buff_wr(sd_buff_wr), .grant(grant)
    );

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [31:0] lba0;
        logic [31:0] lba1;
        logic [1:0]  exp_grant;
        logic        exp_rd;
        logic        exp_wr;
        logic [31:0] exp_lba;
        logic [15:0] exp_din;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    // Wait (bounded) for sd_rd or sd_wr to rise.
    task automatic wait_req(input string name);
        for (int k = 0; k < 20; k++) begin
            if (sd_rd || sd_wr) break;
            cyc();
        end
        chk(name, 32'(sd_rd | sd_wr), 32'd1);
    endtask

    int n_ack0, n_ack1, n_bw0, n_bw1, mism, n_req;
    bit seen_high;

    initial begin
        tbl[0] = '{2'b01, 2'b00, 32'h10,   32'h0,    2'd0, 1'b1, 1'b0, 32'h10,   16'h1111};
        tbl[1] = '{2'b00, 2'b10, 32'h0,    32'h2000, 2'd1, 1'b0, 1'b1, 32'h2000, 16'hBEEF};
        tbl[2] = '{2'b01, 2'b01, 32'hAB,   32'h0,    2'd0, 1'b1, 1'b0, 32'hAB,   16'h1111};
        tbl[3] = '{2'b11, 2'b00, 32'h5,    32'h6,    2'd1, 1'b1, 1'b0, 32'h6,    16'hBEEF};
        tbl[4] = '{2'b11, 2'b00, 32'h5,    32'h6,    2'd0, 1'b1, 1'b0, 32'h5,    16'h1111};
        tbl[5] = '{2'b00, 2'b11, 32'h7,    32'h8,    2'd1, 1'b0, 1'b1, 32'h8,    16'hBEEF};
        tbl[6] = '{2'b10, 2'b00, 32'h0,    32'h9,    2'd1, 1'b1, 1'b0, 32'h9,    16'hBEEF};

        reset = 1'b1;
        ch_lba = 64'd0; ch_rd = 2'b00; ch_wr = 2'b00;
        ch_buff_din = {16'hBEEF, 16'h1111};
        sd_ack = 1'b0; sd_buff_wr = 1'b0; sd_buff_addr = 8'd0; sd_buff_dout = 16'd0;
        cyc(); cyc();
        reset = 1'b0;

        // Reset state
        chk("rst sd_rd", 32'(sd_rd), 32'd0);
        chk("rst sd_wr", 32'(sd_wr), 32'd0);
        chk("rst sd_lba", sd_lba, 32'd0);
        chk("rst grant", 32'(grant), 32'd1);
        chk("rst ch_err", 32'(ch_err), 32'd0);
        chk("rst ch_ack", 32'(ch_ack), 32'd0);
        chk("rst sd_buff_din", 32'(sd_buff_din), 32'd0);

        // sd_ack while idle must be ignored
        sd_ack = 1'b1; #1;
        chk("idle ack ch_ack", 32'(ch_ack), 32'd0);
        cyc(); cyc();
        chk("idle ack sd_rd", 32'(sd_rd), 32'd0);
        chk("idle ack grant", 32'(grant), 32'd1);
        sd_ack = 1'b0;
        cyc();

        // Long ack: 256-cycle ack, 256 buffer strobes to channel 0
        ch_lba = {32'h0, 32'h10}; ch_rd = 2'b01;
        cyc();
        chk("long lat1 sd_rd", 32'(sd_rd), 32'd0);
        ch_rd = 2'b00;
        cyc();
        chk("long sd_rd", 32'(sd_rd), 32'd1);
        chk("long sd_lba", sd_lba, 32'h10);
        chk("long grant", 32'(grant), 32'd0);
        n_ack0 = 0; n_ack1 = 0; n_bw0 = 0; n_bw1 = 0; mism = 0;
        for (int c = 0; c <= 257; c++) begin
            sd_ack = (c < 256);
            sd_buff_wr = (c >= 1 && c <= 256);
            #1;
            if (ch_ack[0]) n_ack0++;
            if (ch_ack[1]) n_ack1++;
            if (ch_ack[0] !== sd_ack) mism++;
            if (ch_buff_wr[0]) n_bw0++;
            if (ch_buff_wr[1]) n_bw1++;
            cyc();
        end
        sd_ack = 1'b0; sd_buff_wr = 1'b0;
        chk("long ch_ack0 count", n_ack0, 256);
        chk("long ch_ack0 mirror", mism, 0);
        chk("long ch_ack1 count", n_ack1, 0);
        chk("long ch_buff_wr0 count", n_bw0, 256);
        chk("long ch_buff_wr1 count", n_bw1, 0);
        $display("txn long: grant=0 acks=%0d strobes=%0d", n_ack0, n_bw0);

        // Fairness: both channels hold rd, grants alternate 0,1,0,1
        pulse_reset();
        ch_lba = {32'h200, 32'h100}; ch_rd = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_req("rr req seen");
            chk("rr grant", 32'(grant), 32'(t % 2));
            chk("rr sd_rd", 32'(sd_rd), 32'd1);
            $display("txn rr %0d: grant=%0d lba=%h", t, grant, sd_lba);
            sd_ack = 1'b1; cyc();
            sd_ack = 1'b0; cyc();
        end
        ch_rd = 2'b00;
        cyc(); cyc();

        // Table-driven single transfers
        pulse_reset();
        for (int i = 0; i < 7; i++) begin
            ch_rd = tbl[i].rd; ch_wr = tbl[i].wr;
            ch_lba = {tbl[i].lba1, tbl[i].lba0};
            cyc();
            chk("tbl latency", 32'({sd_rd, sd_wr}), 32'd0);
            ch_rd = 2'b00; ch_wr = 2'b00; ch_lba = 64'hDEAD_BEEF_CAFE_F00D;
            cyc();
            chk("tbl sd_rd", 32'(sd_rd), 32'(tbl[i].exp_rd));
            chk("tbl sd_wr", 32'(sd_wr), 32'(tbl[i].exp_wr));
            chk("tbl sd_lba", sd_lba, tbl[i].exp_lba);
            chk("tbl grant", 32'(grant), 32'(tbl[i].exp_grant));
            sd_ack = 1'b1; #1;
            chk("tbl ch_ack", 32'(ch_ack), 32'(2'b01 << tbl[i].exp_grant));
            chk("tbl sd_buff_din req", 32'(sd_buff_din), 32'(tbl[i].exp_din));
            cyc();
            chk("tbl xfer rd/wr low", 32'({sd_rd, sd_wr}), 32'd0);
            sd_buff_wr = 1'b1; #1;
            chk("tbl ch_buff_wr", 32'(ch_buff_wr), 32'(2'b01 << tbl[i].exp_grant));
            chk("tbl sd_buff_din xfer", 32'(sd_buff_din), 32'(tbl[i].exp_din));
            sd_ack = 1'b0; sd_buff_wr = 1'b0;
            cyc();
            sd_ack = 1'b1; #1;
            chk("tbl done ack ignored", 32'(ch_ack), 32'd0);
            sd_ack = 1'b0;
            cyc();
            $display("txn tbl %0d: grant=%0d rd=%0b wr=%0b lba=%h", i, grant,
                     tbl[i].exp_rd, tbl[i].exp_wr, tbl[i].exp_lba);
        end

        // Reset during XFER
        pulse_reset();
        ch_lba = {32'h0, 32'h33}; ch_rd = 2'b01;
        cyc();
        ch_rd = 2'b00;
        cyc();
        sd_ack = 1'b1;
        cyc();
        chk("rstx pre ch_ack", 32'(ch_ack), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rstx sd_rd", 32'(sd_rd), 32'd0);
        chk("rstx grant", 32'(grant), 32'd1);
        chk("rstx ch_ack idle", 32'(ch_ack), 32'd0);
        chk("rstx ch_err", 32'(ch_err), 32'd0);
        chk("rstx sd_lba", sd_lba, 32'd0);
        cyc();
        reset = 1'b0; sd_ack = 1'b0;
        $display("txn reset-in-xfer: grant=%0d", grant);

        // Reset during REQ drops sd_rd at once
        ch_rd = 2'b01;
        cyc();
        ch_rd = 2'b00;
        cyc();
        chk("rstr pre sd_rd", 32'(sd_rd), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstr sd_rd", 32'(sd_rd), 32'd0);
        cyc();
        reset = 1'b0;
        $display("txn reset-in-req: sd_rd=%0b", sd_rd);

`ifdef SD_ARB_TIMEOUT_EN
        // Timeout: channel 0 never acked, channel 1 pending
        cyc();
        ch_lba = {32'h77, 32'h66}; ch_rd = 2'b01;
        cyc();
        ch_rd = 2'b11;
        n_req = 0; seen_high = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (sd_rd) seen_high = 1'b1;
            else if (seen_high) break;
            n_req++;
            cyc();
        end
        chk("tmo req cycles", n_req, 16);
        chk("tmo ch_err pulse", 32'(ch_err), 32'd1);
        cyc();
        chk("tmo ch_err clear", 32'(ch_err), 32'd0);
        wait_req("tmo next req");
        chk("tmo next grant", 32'(grant), 32'd1);
        chk("tmo next lba", sd_lba, 32'h77);
        ch_rd = 2'b00;
        sd_ack = 1'b1; cyc();
        sd_ack = 1'b0; cyc(); cyc();
        $display("txn timeout: req_cycles=%0d", n_req);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_chan_arb.md
SD_CHAN_ARB -- requirements
Module: sd_chan_arb

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, meaning the number of block-device requesters (legal range 1..4).
REQ-002 SHALL have parameter BUF_AW, default 8, meaning the sector-buffer address width in 16-bit words.
REQ-003 SHALL have parameter TIMEOUT, default 24'd10_000_000, meaning the cycles to wait for an HPS acknowledge (timeout build only).
REQ-004 SHALL have port clk_sys, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port ch_lba, input, 32*CHANNELS, the per-channel LBA; channel i uses bits [32i+31:32i].
REQ-007 SHALL have ports ch_rd and ch_wr, input, CHANNELS each, the per-channel level read and write requests.
REQ-008 SHALL have port ch_ack, output, CHANNELS, the per-channel acknowledge, mirroring sd_ack to the granted channel only.
REQ-009 SHALL have port ch_buff_wr, output, CHANNELS, the per-channel buffer write strobe.
REQ-010 SHALL have port ch_buff_din, input, 16*CHANNELS, the per-channel write data back toward HPS.
REQ-011 SHALL have port ch_err, output, CHANNELS, the per-channel one-cycle timeout pulse.
REQ-012 SHALL have ports sd_lba (output, 32), sd_rd (output, 1), sd_wr (output, 1), sd_ack (input, 1), sd_buff_addr (input, BUF_AW), sd_buff_dout (input, 16), sd_buff_din (output, 16) and sd_buff_wr (input, 1), forming the shared hps_io block-device side.
REQ-013 SHALL have port grant, output, 2, the index of the current or last granted channel.

Function
REQ-014 SHALL implement FSM states IDLE, REQ, XFER and DONE.
REQ-015 In IDLE, when any ch_rd|ch_wr is set, the FSM SHALL pick a channel round-robin starting at grant+1 (mod CHANNELS), latch its LBA and direction, and enter REQ on the next cycle.
REQ-016 In REQ, sd_rd or sd_wr SHALL be driven from a registered value, with sd_lba held stable for the whole REQ and XFER period.
REQ-017 The FSM SHALL move REQ->XFER on the first cycle sd_ack=1 and deassert sd_rd/sd_wr in that same transition.
REQ-018 The FSM SHALL move XFER->DONE on the first cycle sd_ack=0.
REQ-019 The FSM SHALL move DONE->IDLE after exactly 1 cycle; a requester holding its level request past DONE SHALL be rearbitrated as a new request.
REQ-020 ch_ack[grant] SHALL equal sd_ack combinationally while in REQ or XFER, and all other ch_ack bits SHALL be 0.
REQ-021 ch_buff_wr[grant] SHALL equal sd_buff_wr only in XFER; sd_buff_din SHALL be the granted channel's ch_buff_din slice, and 0 when no channel is granted.
REQ-022 Latency SHALL be: request in IDLE -> sd_rd/sd_wr high 2 cycles later.
REQ-023 If rd and wr are both set on one channel, the request SHALL be treated as a read.
REQ-024 A channel dropping its request after grant SHALL NOT abort the transfer; the FSM SHALL complete the HPS handshake.
REQ-025 An sd_ack seen in IDLE or DONE SHALL be ignored.
REQ-026 With CHANNELS=1, grant SHALL stay 0 and the block SHALL pass requests through with the 2-cycle latency.

Reset
REQ-027 On reset, all of the following SHALL apply asynchronously: state=IDLE; grant=CHANNELS-1 (so channel 0 wins first); sd_rd=sd_wr=0; sd_lba=0; ch_err=0; timeout counter=0.
REQ-028 A reset asserted mid-transfer SHALL drop sd_rd/sd_wr immediately, and no ch_err SHALL be produced.

Configuration
REQ-029 With macro SD_ARB_TIMEOUT_EN defined, a counter SHALL run in REQ; if it reaches TIMEOUT-1 without sd_ack, the FSM SHALL drop sd_rd/sd_wr, pulse ch_err[grant] for 1 cycle and go to DONE.
REQ-030 With SD_ARB_TIMEOUT_EN undefined, REQ SHALL wait indefinitely, ch_err SHALL be tied to 0 and no counter logic SHALL exist.

Verification
REQ-031 Bench SHALL cover: CHANNELS=2, ch_rd=2'b01, LBA0=32'h10 -> sd_rd=1 and sd_lba=32'h10 2 cycles later; sd_ack pulse of 256 cycles -> ch_ack[0] mirrors it, ch_ack[1]=0, and 256 sd_buff_wr strobes reach ch_buff_wr[0] only.
REQ-032 Bench SHALL cover: ch_rd=2'b11 held continuously -> grants alternate 0,1,0,1 across 4 transfers.
REQ-033 Bench SHALL cover: ch_wr[1]=1 with ch_buff_din slice 1=16'hBEEF -> sd_wr=1 and sd_buff_din=16'hBEEF during XFER.
REQ-034 Bench SHALL cover: reset during XFER -> sd_rd=0 in the same cycle, state IDLE, grant=1 (CHANNELS=2).
REQ-035 Bench SHALL cover: SD_ARB_TIMEOUT_EN with TIMEOUT=16 and no sd_ack -> sd_rd drops after 16 cycles in REQ, ch_err[0] pulses 1 cycle, and a pending channel 1 is granted next.
REQ-036 Bench SHALL cover: ch_rd[0] and ch_wr[0] both high -> sd_rd=1, sd_wr=0.
